cp0_unit: RTL

- Coprocessor-0 register file and interrupt arbiter. It sits beside the multi-cycle control FSM and feeds it the IntReq input.
- Consumes the FSM's Wen, EXLSet and EXLClr outputs, plus the rd-field select, the GPR rt data and the restart PC from the datapath.
- Supplies EPC to the NPC unit for eret, and mfc0 read data to the register-write mux.

---
 rtl/cp0_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: Coprocessor-0 register file and interrupt arbiter.
//
// Holds SR (IM/EXL/IE), Cause (IP), EPC and PRId, and raises an interrupt
// request to the multi-cycle control FSM.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   sel_i      CP0 register index (IR[15:11])
//   din_i      mtc0 write data (GPR[rt])
//   wen_i      mtc0 commit strobe
//   pc_i       restart PC, captured into EPC on exception entry
//   hwint_i    level-sensitive device interrupt lines
//   exl_set_i  FSM level; its rising edge marks exception entry
//   exl_clr_i  FSM level; clears EXL while high (eret / post-reset)
//   intreq_o   interrupt request to FSM
//   epc_o      current EPC
//   dout_o     mfc0 read data for sel_i
module cp0_unit #(
  parameter logic [31:0] PRID_VAL  = 32'h0000_4D50,
  parameter int unsigned NUM_HWINT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           sel_i,
  input  logic [31:0]          din_i,
  input  logic                 wen_i,
  input  logic [31:0]          pc_i,
  input  logic [NUM_HWINT-1:0] hwint_i,
  input  logic                 exl_set_i,
  input  logic                 exl_clr_i,
  output logic                 intreq_o,
  output logic [31:0]          epc_o,
  output logic [31:0]          dout_o
);

  localparam logic [4:0] SelSr    = 5'd12;
  localparam logic [4:0] SelCause = 5'd13;
  localparam logic [4:0] SelEpc   = 5'd14;
  localparam logic [4:0] SelPrid  = 5'd15;

  logic [NUM_HWINT-1:0] im_q, im_d;
  logic [NUM_HWINT-1:0] ip_q;
  logic                 exl_q, exl_d;
  logic                 ie_q, ie_d;
  logic [31:0]          epc_q, epc_d;
  logic                 exl_set_q;

  logic set_pulse;
  logic sr_wr;
  logic epc_wr;

  // A held-high exl_set only counts once: entry is its rising edge.
  assign set_pulse = exl_set_i & ~exl_set_q;
  assign sr_wr     = wen_i & (sel_i == SelSr);
  assign epc_wr    = wen_i & (sel_i == SelEpc);

  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    epc_d = epc_q;

    // IM/IE only move on mtc0, even when an exception enters the same cycle.
    if (sr_wr) begin
      im_d = din_i[10 +: NUM_HWINT];
      ie_d = din_i[0];
    end

    if (set_pulse) begin
      exl_d = 1'b1;
    end else if (exl_clr_i) begin
      exl_d = 1'b0;
    end else if (sr_wr) begin
      exl_d = din_i[1];
    end

    if (set_pulse) begin
      epc_d = pc_i;
    end else if (epc_wr) begin
      epc_d = din_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_q      <= '0;
      ip_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      epc_q     <= '0;
      exl_set_q <= 1'b0;
    end else begin
      im_q      <= im_d;
      ip_q      <= hwint_i;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      epc_q     <= epc_d;
      exl_set_q <= exl_set_i;
    end
  end

  // Driven from registers only, so hwint reaches intreq one cycle late.
  assign intreq_o = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign epc_o    = epc_q;

  // Reads show stored values; a same-cycle write is not bypassed.
  always_comb begin
    dout_o = '0;
    unique case (sel_i)
      SelSr: begin
        dout_o[10 +: NUM_HWINT] = im_q;
        dout_o[1]               = exl_q;
        dout_o[0]               = ie_q;
      end
      SelCause: dout_o[10 +: NUM_HWINT] = ip_q;
      SelEpc:   dout_o = epc_q;
      SelPrid:  dout_o = PRID_VAL;
      default:  dout_o = '0;
    endcase
  end

endmodule
